// File: rtl/carfield_region_decoder_if.sv
// Config and lookup port bundle of carfield_region_decoder.
// master: host / crossbar side, slave: the decoder.
interface carfield_region_decoder_if #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned IdxWidth  = 4
);
   logic                 cfg_req_i;
   logic                 cfg_we_i;
   logic [9:0]           cfg_addr_i;
   logic [31:0]          cfg_wdata_i;
   logic                 cfg_gnt_o;
   logic                 cfg_rvalid_o;
   logic [31:0]          cfg_rdata_o;
   logic                 cfg_err_o;
   logic                 lk_valid_i;
   logic                 lk_ready_o;
   logic [AddrWidth-1:0] lk_addr_i;
   logic                 lk_valid_o;
   logic                 lk_ready_i;
   logic [IdxWidth-1:0]  lk_idx_o;
   logic                 lk_hit_o;

   modport master (
      output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, lk_valid_i, lk_addr_i, lk_ready_i,
      input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, lk_ready_o, lk_valid_o,
             lk_idx_o, lk_hit_o
   );

   modport slave (
      input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, lk_valid_i, lk_addr_i, lk_ready_i,
      output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, lk_ready_o, lk_valid_o,
             lk_idx_o, lk_hit_o
   );
endinterface

// File: rtl/carfield_region_decoder.sv
// Runtime-programmable address-map decoder for the Carfield island ports.
// NumRegions base/size windows with enable and sticky lock, 1-stage lookup
// pipeline with lowest-index priority, saturating decode-error counter.
// Optional macro CARFIELD_REGION_DEC_ERRLOG_EN adds the ERRADDR first-miss log.
module carfield_region_decoder #(
   parameter int unsigned NumRegions = 8,
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned IdxWidth   = 4,
   parameter int unsigned CntWidth   = 16,
   parameter logic [NumRegions-1:0][63:0] RstBase = '0,
   parameter logic [NumRegions-1:0][63:0] RstSize = '0,
   parameter logic [NumRegions-1:0]       RstEn   = '0
) (
   input logic                    clk_i,
   input logic                    rst_i,
   carfield_region_decoder_if.slave bus
);

   logic [AddrWidth-1:0] base_q [NumRegions];
   logic [AddrWidth-1:0] size_q [NumRegions];
   logic [63:0]          base64 [NumRegions];
   logic [63:0]          size64 [NumRegions];
   logic [AddrWidth:0]   lim    [NumRegions];
   logic [NumRegions-1:0] en_q, lock_q, match, rwe;
   logic [CntWidth-1:0]  cnt_q;

   logic                 rvalid_q, err_q;
   logic [31:0]          rdata_q;
   logic                 lk_valid_q, lk_hit_q;
   logic [IdxWidth-1:0]  lk_idx_q;

   logic                 aligned, reg_space, cnt_clr;
   logic [3:0]           ridx;
   logic [2:0]           roff;
   logic [6:0]           gword;
   logic [31:0]          rd_data;
   logic                 rd_err, rd_locked, rd_mapped;
   logic                 m_hit, lk_ready, lk_accept, lk_miss;
   logic [IdxWidth-1:0]  m_idx;

   assign aligned   = (bus.cfg_addr_i[1:0] == 2'b00);
   assign reg_space = !bus.cfg_addr_i[9];
   assign ridx      = bus.cfg_addr_i[8:5];
   assign roff      = bus.cfg_addr_i[4:2];
   assign gword     = bus.cfg_addr_i[8:2];
   assign cnt_clr   = bus.cfg_req_i && bus.cfg_we_i && aligned && !reg_space && (gword == 7'd0);

   assign lk_ready  = !lk_valid_q || bus.lk_ready_i;
   assign lk_accept = bus.lk_valid_i && lk_ready;
   assign lk_miss   = lk_accept && !m_hit;

   for (genvar g = 0; g < NumRegions; g++) begin : g_region
      assign base64[g] = 64'(base_q[g]);
      assign size64[g] = 64'(size_q[g]);
      // Window end kept one bit wider so windows at the top of the space do not wrap.
      assign lim[g]    = {1'b0, base_q[g]} + {1'b0, size_q[g]};
      assign match[g]  = en_q[g] && (size_q[g] != '0) && (bus.lk_addr_i >= base_q[g]) &&
                         ({1'b0, bus.lk_addr_i} < lim[g]);
      assign rwe[g]    = bus.cfg_req_i && bus.cfg_we_i && aligned && reg_space &&
                         (ridx == 4'(g)) && !lock_q[g];
   end

`ifdef CARFIELD_REGION_DEC_ERRLOG_EN
   logic [AddrWidth-1:0] eaddr_q;
   logic [63:0]          eaddr64;
   assign eaddr64 = 64'(eaddr_q);

   // First-miss address log, cleared together with the error counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         eaddr_q <= '0;
      end else if (cnt_clr) begin
         eaddr_q <= lk_miss ? bus.lk_addr_i : '0;
      end else if (lk_miss && (cnt_q == '0)) begin
         eaddr_q <= bus.lk_addr_i;
      end
   end
`endif

   // Config read mux and access-error decode.
   always_comb begin
      rd_data   = '0;
      rd_err    = 1'b0;
      rd_locked = 1'b0;
      rd_mapped = 1'b0;
      if (!aligned) begin
         rd_err = 1'b1;
      end else if (reg_space) begin
         for (int i = 0; i < int'(NumRegions); i++) begin
            if (ridx == 4'(i)) begin
               rd_mapped = 1'b1;
               rd_locked = lock_q[i];
               case (roff)
                  3'd0:    rd_data = base64[i][31:0];
                  3'd1:    rd_data = base64[i][63:32];
                  3'd2:    rd_data = size64[i][31:0];
                  3'd3:    rd_data = size64[i][63:32];
                  3'd4:    rd_data = {30'd0, lock_q[i], en_q[i]};
                  default: rd_mapped = 1'b0;
               endcase
            end
         end
         rd_err = !rd_mapped;
      end else begin
         case (gword)
            7'd0:    rd_data = 32'(cnt_q);
`ifdef CARFIELD_REGION_DEC_ERRLOG_EN
            7'd1:    rd_data = eaddr64[31:0];
            7'd2:    rd_data = eaddr64[63:32];
`endif
            default: rd_err = 1'b1;
         endcase
      end
   end

   // Config response, one cycle after the grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= bus.cfg_req_i;
         rdata_q  <= (bus.cfg_req_i && !bus.cfg_we_i) ? rd_data : '0;
         err_q    <= bus.cfg_req_i && (rd_err || (bus.cfg_we_i && rd_locked));
      end
   end

   // Region map state; lock is sticky until reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NumRegions); i++) begin
            base_q[i] <= AddrWidth'(RstBase[i]);
            size_q[i] <= AddrWidth'(RstSize[i]);
            en_q[i]   <= RstEn[i];
            lock_q[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < int'(NumRegions); i++) begin
            if (rwe[i]) begin
               case (roff)
                  3'd0: base_q[i] <= AddrWidth'({base64[i][63:32], bus.cfg_wdata_i});
                  3'd1: base_q[i] <= AddrWidth'({bus.cfg_wdata_i, base64[i][31:0]});
                  3'd2: size_q[i] <= AddrWidth'({size64[i][63:32], bus.cfg_wdata_i});
                  3'd3: size_q[i] <= AddrWidth'({bus.cfg_wdata_i, size64[i][31:0]});
                  3'd4: begin
                     en_q[i] <= bus.cfg_wdata_i[0];
                     if (bus.cfg_wdata_i[1]) lock_q[i] <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Priority select: lowest matching index wins.
   always_comb begin
      m_hit = 1'b0;
      m_idx = '0;
      for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
         if (match[i]) begin
            m_hit = 1'b1;
            m_idx = IdxWidth'(i);
         end
      end
   end

   // Lookup result stage, held while the consumer stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lk_valid_q <= 1'b0;
         lk_idx_q   <= '0;
         lk_hit_q   <= 1'b0;
      end else if (lk_accept) begin
         lk_valid_q <= 1'b1;
         lk_idx_q   <= m_idx;
         lk_hit_q   <= m_hit;
      end else if (bus.lk_ready_i) begin
         lk_valid_q <= 1'b0;
      end
   end

   // Saturating decode-error counter; a same-cycle clear and miss leaves 1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= lk_miss ? CntWidth'(1) : '0;
      end else if (lk_miss && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CntWidth'(1);
      end
   end

   assign bus.cfg_gnt_o    = bus.cfg_req_i;
   assign bus.cfg_rvalid_o = rvalid_q;
   assign bus.cfg_rdata_o  = rdata_q;
   assign bus.cfg_err_o    = err_q;
   assign bus.lk_ready_o   = lk_ready;
   assign bus.lk_valid_o   = lk_valid_q;
   assign bus.lk_idx_o     = lk_idx_q;
   assign bus.lk_hit_o     = lk_hit_q;

endmodule

// File: tb/tb_carfield_region_decoder.sv
// Self-checking bench for carfield_region_decoder against an address-map model.
module tb_carfield_region_decoder;

   localparam int unsigned NR = 8;
   localparam int unsigned AW = 48;
   localparam int unsigned IW = 4;
   localparam int unsigned CW = 4;
   localparam int          CNT_MAX = 15;
   localparam logic [NR-1:0][63:0] RB = 512'h7800_0000;
   localparam logic [NR-1:0][63:0] RS = 512'h0020_0000;
   localparam logic [NR-1:0]       RE = 8'h01;
   localparam logic [63:0] AMASK = 64'h0000_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   carfield_region_decoder_if #(.AddrWidth(AW), .IdxWidth(IW)) bus ();

   carfield_region_decoder #(
      .NumRegions(NR), .AddrWidth(AW), .IdxWidth(IW), .CntWidth(CW),
      .RstBase(RB), .RstSize(RS), .RstEn(RE)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   // ---------------- reference model ----------------
   logic [63:0] m_base [NR];
   logic [63:0] m_size [NR];
   bit          m_en   [NR];
   bit          m_lock [NR];
   int          m_cnt;
   logic [63:0] m_eaddr;

   function automatic void model_reset();
      for (int i = 0; i < int'(NR); i++) begin
         m_base[i] = 64'd0; m_size[i] = 64'd0; m_en[i] = 1'b0; m_lock[i] = 1'b0;
      end
      m_base[0] = 64'h7800_0000; m_size[0] = 64'h20_0000; m_en[0] = 1'b1;
      m_cnt = 0; m_eaddr = 64'd0;
   endfunction

   function automatic void model_lookup(input logic [63:0] a, output int idx, output bit hit);
      logic [64:0] top;
      hit = 1'b0; idx = 0;
      for (int i = 0; i < int'(NR); i++) begin
         top = {1'b0, m_base[i]} + {1'b0, m_size[i]};
         if (!hit && m_en[i] && m_size[i] != 64'd0 && a >= m_base[i] && {1'b0, a} < top) begin
            hit = 1'b1; idx = i;
         end
      end
   endfunction

   function automatic void model_miss(input logic [63:0] a);
      if (m_cnt == 0) m_eaddr = a;
      if (m_cnt < CNT_MAX) m_cnt++;
   endfunction

   function automatic void model_cfg(input bit we, input logic [9:0] a, input logic [31:0] d,
                                     output logic [31:0] rd, output bit err);
      int ai, r, o;
      ai = int'(a); rd = 32'd0; err = 1'b0;
      r = ai / 32; o = ai % 32;
      if (ai % 4 != 0) err = 1'b1;
      else if (ai < 'h200) begin
         if (r >= int'(NR) || o > 16) err = 1'b1;
         else if (we) begin
            if (m_lock[r]) err = 1'b1;
            else case (o)
               0:  m_base[r] = {m_base[r][63:32], d} & AMASK;
               4:  m_base[r] = {d, m_base[r][31:0]} & AMASK;
               8:  m_size[r] = {m_size[r][63:32], d} & AMASK;
               12: m_size[r] = {d, m_size[r][31:0]} & AMASK;
               default: begin m_en[r] = d[0]; if (d[1]) m_lock[r] = 1'b1; end
            endcase
         end else case (o)
            0:  rd = m_base[r][31:0];
            4:  rd = m_base[r][63:32];
            8:  rd = m_size[r][31:0];
            12: rd = m_size[r][63:32];
            default: rd = {30'd0, m_lock[r], m_en[r]};
         endcase
      end else if (ai == 'h200) begin
         if (we) begin m_cnt = 0; m_eaddr = 64'd0; end
         else rd = 32'(m_cnt);
      end else if (ai == 'h204 || ai == 'h208) begin
`ifdef CARFIELD_REGION_DEC_ERRLOG_EN
         if (!we) rd = (ai == 'h204) ? m_eaddr[31:0] : m_eaddr[63:32];
`else
         err = 1'b1;
`endif
      end else err = 1'b1;
   endfunction

   // ---------------- bus drivers ----------------
   logic [33:0] cg, ce;
   logic [5:0]  lg, le;

   task automatic cfg_do(input bit we, input logic [9:0] a, input logic [31:0] d,
                         output logic [33:0] got, output logic [33:0] exp);
      logic [31:0] mrd; bit merr;
      model_cfg(we, a, d, mrd, merr);
      bus.cfg_req_i = 1'b1; bus.cfg_we_i = we; bus.cfg_addr_i = a; bus.cfg_wdata_i = d;
      @(posedge clk); #1;
      got = {bus.cfg_rvalid_o, bus.cfg_err_o, bus.cfg_rdata_o};
      exp = {1'b1, merr, mrd};
      bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0;
   endtask

   task automatic lk_do(input logic [AW-1:0] a, output logic [5:0] got, output logic [5:0] exp);
      int ei; bit eh;
      model_lookup(64'(a), ei, eh);
      if (!eh) model_miss(64'(a));
      bus.lk_addr_i = a; bus.lk_valid_i = 1'b1; bus.lk_ready_i = 1'b1;
      @(posedge clk); #1;
      got = {bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o};
      exp = {1'b1, eh, 4'(ei)};
      bus.lk_valid_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.cfg_req_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({bus.cfg_rvalid_o, bus.cfg_rdata_o, bus.cfg_err_o, bus.lk_valid_o, bus.lk_idx_o, bus.lk_hit_o} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got=%h exp=0", {bus.cfg_rvalid_o, bus.cfg_rdata_o,
            bus.cfg_err_o, bus.lk_valid_o, bus.lk_idx_o, bus.lk_hit_o});
      end
      n_chk++;
      if ({bus.cfg_gnt_o, bus.lk_ready_o} !== 2'b11) begin
         n_fail++; $display("FAIL reset_gnt_ready got=%b exp=11", {bus.cfg_gnt_o, bus.lk_ready_o});
      end
      bus.cfg_req_i = 1'b0;
      #1;
      n_chk++;
      if (bus.cfg_gnt_o !== 1'b0) begin n_fail++; $display("FAIL gnt_follows_req got=%b exp=0", bus.cfg_gnt_o); end
      rst = 1'b0;
      model_reset();
      cfg_do(0, 10'h000, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h7800_0000}) begin n_fail++; $display("FAIL reset_base0 got=%h exp=%h", cg, {2'b10, 32'h7800_0000}); end
      cfg_do(0, 10'h008, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0020_0000}) begin n_fail++; $display("FAIL reset_size0 got=%h exp=%h", cg, {2'b10, 32'h0020_0000}); end
      cfg_do(0, 10'h010, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h1}) begin n_fail++; $display("FAIL reset_ctrl0 got=%h exp=%h", cg, {2'b10, 32'h1}); end
      cfg_do(0, 10'h030, 0, cg, ce);
      n_chk++; if (cg !== ce) begin n_fail++; $display("FAIL reset_ctrl1 got=%h exp=%h", cg, ce); end
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL reset_errcnt got=%h exp=0", cg); end
   endtask

   task automatic test_basic_hit();
      n_chk++; if (bus.lk_valid_o !== 1'b0) begin n_fail++; $display("FAIL pre_lookup_valid got=%b exp=0", bus.lk_valid_o); end
      lk_do(48'h7800_0000_0000 >> 16 | 48'h781F_FFFC, lg, le);
      n_chk++; if (lg !== 6'b11_0000) begin n_fail++; $display("FAIL hit_region0 got=%b exp=110000", lg); end
      @(posedge clk); #1;
      n_chk++; if (bus.lk_valid_o !== 1'b0) begin n_fail++; $display("FAIL result_drops got=%b exp=0", bus.lk_valid_o); end
   endtask

   task automatic test_miss();
      lk_do(48'h7820_0000, lg, le);
      n_chk++; if (lg !== 6'b10_0000) begin n_fail++; $display("FAIL miss_end_of_region0 got=%b exp=100000", lg); end
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h1}) begin n_fail++; $display("FAIL errcnt_one got=%h exp=%h", cg, {2'b10, 32'h1}); end
   endtask

   task automatic test_overlap();
      cfg_do(1, 10'h020, 32'h6000_0000, cg, ce);
      cfg_do(1, 10'h028, 32'h0000_1000, cg, ce);
      cfg_do(1, 10'h030, 32'h1, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL ctrl1_write got=%h exp=%h", cg, {2'b10, 32'h0}); end
      cfg_do(1, 10'h040, 32'h5FFF_F000, cg, ce);
      cfg_do(1, 10'h048, 32'h0000_2000, cg, ce);
      cfg_do(1, 10'h050, 32'h1, cg, ce);
      lk_do(48'h6000_0000, lg, le);
      n_chk++; if (lg !== 6'b11_0001) begin n_fail++; $display("FAIL overlap_low_index got=%b exp=110001", lg); end
      lk_do(48'h5FFF_F800, lg, le);
      n_chk++; if (lg !== 6'b11_0010) begin n_fail++; $display("FAIL region2_only got=%b exp=110010", lg); end
      lk_do(48'h6000_0FFF, lg, le);
      n_chk++; if (lg !== 6'b11_0001) begin n_fail++; $display("FAIL region1_last got=%b exp=110001", lg); end
      lk_do(48'h6000_1000, lg, le);
      n_chk++; if (lg !== 6'b10_0000) begin n_fail++; $display("FAIL region2_end_excl got=%b exp=100000", lg); end
   endtask

   task automatic test_lock();
      cfg_do(1, 10'h010, 32'h3, cg, ce);
      n_chk++; if (cg[33:32] !== 2'b10) begin n_fail++; $display("FAIL lock_set_resp got=%b exp=10", cg[33:32]); end
      cfg_do(1, 10'h000, 32'h5000_0000, cg, ce);
      n_chk++; if (cg[33:32] !== 2'b11) begin n_fail++; $display("FAIL locked_write_err got=%b exp=11", cg[33:32]); end
      cfg_do(0, 10'h000, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h7800_0000}) begin n_fail++; $display("FAIL locked_base_kept got=%h exp=%h", cg, {2'b10, 32'h7800_0000}); end
      cfg_do(1, 10'h010, 32'h0, cg, ce);
      n_chk++; if (cg[33:32] !== 2'b11) begin n_fail++; $display("FAIL locked_ctrl_err got=%b exp=11", cg[33:32]); end
      cfg_do(0, 10'h010, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h3}) begin n_fail++; $display("FAIL lock_sticky got=%h exp=%h", cg, {2'b10, 32'h3}); end
      lk_do(48'h7800_0000, lg, le);
      n_chk++; if (lg !== 6'b11_0000) begin n_fail++; $display("FAIL locked_region_hits got=%b exp=110000", lg); end
   endtask

   task automatic test_upper_bits();
      cfg_do(1, 10'h064, 32'hFFFF_FFFF, cg, ce);
      cfg_do(0, 10'h064, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0000_FFFF}) begin n_fail++; $display("FAIL base_hi_trunc got=%h exp=%h", cg, {2'b10, 32'h0000_FFFF}); end
      cfg_do(1, 10'h06C, 32'hABCD_1234, cg, ce);
      cfg_do(0, 10'h06C, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0000_1234}) begin n_fail++; $display("FAIL size_hi_trunc got=%h exp=%h", cg, {2'b10, 32'h0000_1234}); end
      cfg_do(1, 10'h06C, 32'h0, cg, ce);
      cfg_do(1, 10'h060, 32'hFFFF_F000, cg, ce);
      cfg_do(1, 10'h068, 32'h0000_2000, cg, ce);
      cfg_do(1, 10'h070, 32'h1, cg, ce);
      lk_do(48'hFFFF_FFFF_FFFF, lg, le);
      n_chk++; if (lg !== 6'b11_0011) begin n_fail++; $display("FAIL top_of_space_hit got=%b exp=110011", lg); end
      lk_do(48'h0000_0000_0010, lg, le);
      n_chk++; if (lg !== 6'b10_0000) begin n_fail++; $display("FAIL no_wrap got=%b exp=100000", lg); end
   endtask

   task automatic test_unmapped();
      logic [9:0] addrs [6];
      addrs = '{10'h014, 10'h100, 10'h3FC, 10'h002, 10'h204, 10'h208};
      foreach (addrs[k]) begin
         cfg_do(0, addrs[k], 0, cg, ce);
         n_chk++; if (cg !== ce) begin n_fail++; $display("FAIL unmapped_rd_%h got=%h exp=%h", addrs[k], cg, ce); end
      end
      cfg_do(1, 10'h018, 32'h1234, cg, ce);
      n_chk++; if (cg !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL unmapped_wr got=%h exp=%h", cg, {2'b11, 32'h0}); end
   endtask

   task automatic test_same_cycle();
      int ei; bit eh; logic [31:0] mrd; bit merr;
      cfg_do(1, 10'h080, 32'h4000_0000, cg, ce);
      cfg_do(1, 10'h088, 32'h0000_0100, cg, ce);
      model_lookup(64'h4000_0010, ei, eh);
      if (!eh) model_miss(64'h4000_0010);
      model_cfg(1'b1, 10'h090, 32'h1, mrd, merr);
      bus.cfg_req_i = 1'b1; bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 10'h090; bus.cfg_wdata_i = 32'h1;
      bus.lk_valid_i = 1'b1; bus.lk_ready_i = 1'b1; bus.lk_addr_i = 48'h4000_0010;
      @(posedge clk); #1;
      bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.lk_valid_i = 1'b0;
      n_chk++; if ({bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o} !== 6'b10_0000) begin
         n_fail++; $display("FAIL same_cycle_pre_map got=%b exp=100000", {bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o});
      end
      lk_do(48'h4000_0010, lg, le);
      n_chk++; if (lg !== 6'b11_0100) begin n_fail++; $display("FAIL post_write_hit got=%b exp=110100", lg); end
   endtask

   task automatic test_backpressure();
      int ei; bit eh;
      model_lookup(64'h4000_0020, ei, eh);
      bus.lk_ready_i = 1'b0; bus.lk_valid_i = 1'b1; bus.lk_addr_i = 48'h4000_0020;
      @(posedge clk); #1;
      bus.lk_addr_i = 48'h0000_0000;
      for (int k = 0; k < 3; k++) begin
         n_chk++; if ({bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o, bus.lk_ready_o} !== 7'b11_0100_0) begin
            n_fail++; $display("FAIL stall_hold_%0d got=%b exp=1101000", k,
               {bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o, bus.lk_ready_o});
         end
         @(posedge clk); #1;
      end
      bus.lk_ready_i = 1'b1;
      #1;
      n_chk++; if (bus.lk_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", bus.lk_ready_o); end
      model_lookup(64'h0, ei, eh);
      if (!eh) model_miss(64'h0);
      @(posedge clk); #1;
      bus.lk_valid_i = 1'b0;
      n_chk++; if ({bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o} !== 6'b10_0000) begin
         n_fail++; $display("FAIL next_accepted got=%b exp=100000", {bus.lk_valid_o, bus.lk_hit_o, bus.lk_idx_o});
      end
   endtask

   task automatic test_counter();
      cfg_do(1, 10'h200, 32'h0, cg, ce);
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL errcnt_cleared got=%h exp=0", cg); end
      for (int k = 0; k < 20; k++) lk_do(48'h1000 + 48'(k), lg, le);
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'(CNT_MAX)}) begin n_fail++; $display("FAIL errcnt_saturate got=%h exp=%h", cg, {2'b10, 32'(CNT_MAX)}); end
      model_cfg(1'b1, 10'h200, 32'h0, ce[31:0], ce[32]);
      model_miss(64'h0000_0777);
      bus.cfg_req_i = 1'b1; bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 10'h200; bus.cfg_wdata_i = 32'h0;
      bus.lk_valid_i = 1'b1; bus.lk_ready_i = 1'b1; bus.lk_addr_i = 48'h0000_0777;
      @(posedge clk); #1;
      bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.lk_valid_i = 1'b0;
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h1}) begin n_fail++; $display("FAIL clear_and_miss got=%h exp=%h", cg, {2'b10, 32'h1}); end
   endtask

`ifdef CARFIELD_REGION_DEC_ERRLOG_EN
   task automatic test_errlog();
      cfg_do(1, 10'h200, 32'h0, cg, ce);
      lk_do(48'h10, lg, le);
      lk_do(48'h20, lg, le);
      cfg_do(0, 10'h204, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h10}) begin n_fail++; $display("FAIL erraddr_first got=%h exp=%h", cg, {2'b10, 32'h10}); end
      cfg_do(1, 10'h200, 32'h0, cg, ce);
      lk_do(48'h30, lg, le);
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h1}) begin n_fail++; $display("FAIL errlog_cnt got=%h exp=%h", cg, {2'b10, 32'h1}); end
      cfg_do(0, 10'h204, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h30}) begin n_fail++; $display("FAIL erraddr_after_clr got=%h exp=%h", cg, {2'b10, 32'h30}); end
      cfg_do(0, 10'h208, 0, cg, ce);
      n_chk++; if (cg !== ce) begin n_fail++; $display("FAIL erraddr_hi got=%h exp=%h", cg, ce); end
   endtask
`endif

   task automatic test_random();
      logic [9:0]  a;
      logic [31:0] d;
      int          sel, off;
      for (int k = 0; k < 300; k++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 3) begin
            off = int'($urandom_range(0, 4)) * 4;
            a   = 10'(int'($urandom_range(4, 7)) * 32 + off);
            case (off)
               0:       d = 32'($urandom_range(0, 15)) << 12;
               8:       d = 32'($urandom_range(0, 3)) << 12;
               16:      d = ($urandom_range(0, 19) == 0) ? 32'h3 : 32'($urandom_range(0, 1));
               default: d = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0;
            endcase
            cfg_do(1, a, d, cg, ce);
            n_chk++; if (cg !== ce) begin n_fail++; $display("FAIL rand_wr_%0d a=%h got=%h exp=%h", k, a, cg, ce); end
         end else if (sel < 5) begin
            a = 10'($urandom_range(0, 10'h20C)) & 10'h3FC;
            cfg_do(0, a, 0, cg, ce);
            n_chk++; if (cg !== ce) begin n_fail++; $display("FAIL rand_rd_%0d a=%h got=%h exp=%h", k, a, cg, ce); end
         end else begin
            lk_do(48'($urandom_range(0, 32'h12000)), lg, le);
            n_chk++; if (lg !== le) begin n_fail++; $display("FAIL rand_lk_%0d a=%h got=%b exp=%b", k, bus.lk_addr_i, lg, le); end
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.lk_ready_i = 1'b0; bus.lk_valid_i = 1'b1; bus.lk_addr_i = 48'h7800_0000;
      bus.cfg_req_i = 1'b1; bus.cfg_we_i = 1'b0; bus.cfg_addr_i = 10'h010;
      @(posedge clk); #1;
      bus.lk_valid_i = 1'b0;
      n_chk++; if ({bus.lk_valid_o, bus.cfg_rvalid_o} !== 2'b11) begin n_fail++; $display("FAIL pre_rst_busy got=%b exp=11", {bus.lk_valid_o, bus.cfg_rvalid_o}); end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({bus.cfg_rvalid_o, bus.cfg_rdata_o, bus.cfg_err_o, bus.lk_valid_o, bus.lk_idx_o, bus.lk_hit_o} !== '0) begin
         n_fail++; $display("FAIL async_rst_clears got=%h exp=0", {bus.cfg_rvalid_o, bus.cfg_rdata_o,
            bus.cfg_err_o, bus.lk_valid_o, bus.lk_idx_o, bus.lk_hit_o});
      end
      bus.cfg_req_i = 1'b0; bus.lk_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      cfg_do(0, 10'h010, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h1}) begin n_fail++; $display("FAIL rst_unlocks got=%h exp=%h", cg, {2'b10, 32'h1}); end
      cfg_do(0, 10'h030, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL rst_region1_off got=%h exp=0", cg); end
      cfg_do(0, 10'h200, 0, cg, ce);
      n_chk++; if (cg !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL rst_errcnt got=%h exp=0", cg); end
      cfg_do(1, 10'h000, 32'h5000_0000, cg, ce);
      n_chk++; if (cg[33:32] !== 2'b10) begin n_fail++; $display("FAIL rst_write_ok got=%b exp=10", cg[33:32]); end
      lk_do(48'h5000_0100, lg, le);
      n_chk++; if (lg !== 6'b11_0000) begin n_fail++; $display("FAIL rst_new_base_hit got=%b exp=110000", lg); end
   endtask

   initial begin
      bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_wdata_i = '0;
      bus.lk_valid_i = 1'b0; bus.lk_addr_i = '0; bus.lk_ready_i = 1'b1;
      model_reset();
      test_reset();
      test_basic_hit();
      test_miss();
      test_overlap();
      test_lock();
      test_upper_bits();
      test_unmapped();
      test_same_cycle();
      test_backpressure();
      test_counter();
`ifdef CARFIELD_REGION_DEC_ERRLOG_EN
      test_errlog();
`endif
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
